// File: rtl/apb_master_pkg.sv
// Shared types and default parameters for the APB master bridge.
package apb_master_pkg;

    localparam int unsigned DEF_PADDR_WIDTH    = 32;
    localparam int unsigned DEF_PWDATA_WIDTH   = 32;
    localparam int unsigned DEF_PRDATA_WIDTH   = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_master_state_e;

endpackage

// File: rtl/apb_master_timeout.sv
// Saturating wait-state counter; expired asserts once the count has reached limit.
module apb_master_timeout #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             pclock,
    input  logic             preset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Saturates at all-ones so a very long stall can never wrap back to zero.
    always_ff @(posedge pclock) begin
        if (preset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to single APB transfers, with a wait-state timeout.
module apb_master_bridge #(
    parameter int unsigned PADDR_WIDTH    = apb_master_pkg::DEF_PADDR_WIDTH,
    parameter int unsigned PWDATA_WIDTH   = apb_master_pkg::DEF_PWDATA_WIDTH,
    parameter int unsigned PRDATA_WIDTH   = apb_master_pkg::DEF_PRDATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = apb_master_pkg::DEF_TIMEOUT_CYCLES
) (
    input  logic                    pclock,
    input  logic                    preset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [PADDR_WIDTH-1:0]  req_addr,
    input  logic [PWDATA_WIDTH-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [PRDATA_WIDTH-1:0] rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic [PADDR_WIDTH-1:0]  paddr,
    output logic                    prwd,
    output logic [PWDATA_WIDTH-1:0] pwdata,
    output logic                    psel,
    output logic                    penable,
    input  logic [PRDATA_WIDTH-1:0] prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    import apb_master_pkg::*;

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LIMIT      = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

    apb_master_state_e state, state_d;

    logic [PADDR_WIDTH-1:0]  paddr_d;
    logic [PWDATA_WIDTH-1:0] pwdata_d;
    logic [PRDATA_WIDTH-1:0] rsp_rdata_d;
    logic prwd_d, psel_d, penable_d;
    logic rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
    logic cnt_clear, cnt_enable, cnt_expired, timeout_hit;

    assign req_ready   = (state == APB_IDLE) && !preset;
    assign timeout_hit = TIMEOUT_ON && cnt_expired;

    apb_master_timeout #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .pclock  (pclock),
        .preset  (preset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .limit   (CNT_W'(LIMIT)),
        .expired (cnt_expired)
    );

    // State and all registered outputs.
    always_ff @(posedge pclock) begin
        if (preset) begin
            state       <= APB_IDLE;
            paddr       <= '0;
            pwdata      <= '0;
            prwd        <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            prwd        <= prwd_d;
            psel        <= psel_d;
            penable     <= penable_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_slverr  <= rsp_slverr_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    // Next state and next output values; response fields default to zero so they pulse.
    always_comb begin
        state_d       = state;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        prwd_d        = prwd;
        psel_d        = psel;
        penable_d     = penable;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_slverr_d  = 1'b0;
        rsp_timeout_d = 1'b0;
        cnt_clear     = 1'b0;
        cnt_enable    = 1'b0;

        case (state)
            APB_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d   = APB_SETUP;
                    paddr_d   = req_addr;
                    pwdata_d  = req_write ? req_wdata : '0;
                    prwd_d    = req_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_clear = 1'b1;
                end
            end
            APB_SETUP: begin
                state_d   = APB_ACCESS;
                penable_d = 1'b1;
            end
            APB_ACCESS: begin
                // A completion on the timeout edge takes priority over the abort.
                if (pready) begin
                    state_d      = APB_IDLE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = prwd ? '0 : prdata;
                    rsp_slverr_d = pslverr;
                end else if (timeout_hit) begin
                    state_d       = APB_IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            default: begin
                state_d   = APB_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 4-cycle timeout instance.
module tb_apb_master_bridge;

    logic        pclock = 1'b0;
    logic        preset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        prwd, psel, penable, pready, pslverr;

    int errors = 0;
    int checks = 0;

    always #5 pclock = ~pclock;

    apb_master_bridge #(
        .PADDR_WIDTH    (32),
        .PWDATA_WIDTH   (32),
        .PRDATA_WIDTH   (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclock      (pclock),
        .preset      (preset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .prwd        (prwd),
        .pwdata      (pwdata),
        .psel        (psel),
        .penable     (penable),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclock);
        @(negedge pclock);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        cyc();
        req_valid = 1'b0;
    endtask

    initial begin
        int k;
        int r;
        preset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        cyc();
        cyc();
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        preset = 1'b0;
        #1;
        check("idle_req_ready", 64'(req_ready), 64'd1);

        // Zero-wait write
        pready = 1'b1;
        issue(1'b1, 32'h100, 32'hDEADBEEF);
        check("wr_setup_psel", 64'(psel), 64'd1);
        check("wr_setup_penable", 64'(penable), 64'd0);
        check("wr_paddr", 64'(paddr), 64'h100);
        check("wr_pwdata", 64'(pwdata), 64'hDEADBEEF);
        check("wr_prwd", 64'(prwd), 64'd1);
        check("wr_setup_ready", 64'(req_ready), 64'd0);
        cyc();
        check("wr_access_psel", 64'(psel), 64'd1);
        check("wr_access_penable", 64'(penable), 64'd1);
        check("wr_access_rsp", 64'(rsp_valid), 64'd0);
        cyc();
        check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr_rsp_slverr", 64'(rsp_slverr), 64'd0);
        check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("wr_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("wr_rsp_psel", 64'(psel), 64'd0);
        check("wr_rsp_ready", 64'(req_ready), 64'd1);
        check("wr_idle_paddr_hold", 64'(paddr), 64'h100);
        cyc();
        check("wr_rsp_pulse_end", 64'(rsp_valid), 64'd0);

        // Read, three wait states; completes on the timeout boundary cycle
        pready = 1'b0;
        issue(1'b0, 32'h204, 32'hFFFF_FFFF);
        check("rd_pwdata_zero", 64'(pwdata), 64'd0);
        check("rd_prwd", 64'(prwd), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rd_paddr_%0d", i), 64'(paddr), 64'h204);
            check($sformatf("rd_psel_%0d", i), 64'(psel), 64'd1);
            check($sformatf("rd_norsp_%0d", i), 64'(rsp_valid), 64'd0);
            if (i == 4) begin
                pready = 1'b1;
                prdata = 32'h12345678;
            end
            cyc();
        end
        check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
        check("rd_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("rd_rsp_slverr", 64'(rsp_slverr), 64'd0);
        cyc();
        check("rd_rdata_clear", 64'(rsp_rdata), 64'd0);

        // Slave error then a clean write
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h0000A5A5;
        issue(1'b0, 32'h8, 32'h0);
        cyc();
        cyc();
        check("err_rsp_valid", 64'(rsp_valid), 64'd1);
        check("err_rsp_slverr", 64'(rsp_slverr), 64'd1);
        check("err_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("err_rsp_rdata", 64'(rsp_rdata), 64'h0000A5A5);
        pslverr = 1'b0;
        issue(1'b1, 32'h10, 32'h55);
        check("err_slverr_clear", 64'(rsp_slverr), 64'd0);
        cyc();
        cyc();
        check("err_wr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("err_wr_rsp_slverr", 64'(rsp_slverr), 64'd0);

        // Timeout with pready held low
        pready = 1'b0;
        prdata = 32'hCAFEF00D;
        issue(1'b0, 32'h40, 32'h0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_psel_%0d", i), 64'(psel), 64'd1);
            check($sformatf("to_norsp_%0d", i), 64'(rsp_valid), 64'd0);
            cyc();
        end
        check("to_rsp_valid", 64'(rsp_valid), 64'd1);
        check("to_rsp_slverr", 64'(rsp_slverr), 64'd1);
        check("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
        check("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("to_psel", 64'(psel), 64'd0);
        check("to_penable", 64'(penable), 64'd0);
        cyc();
        check("to_timeout_clear", 64'(rsp_timeout), 64'd0);

        // Reset during ACCESS
        issue(1'b1, 32'h80, 32'h1234);
        cyc();
        cyc();
        check("rm_in_access", 64'(penable), 64'd1);
        preset = 1'b1;
        #1;
        check("rm_ready_in_reset", 64'(req_ready), 64'd0);
        pready = 1'b1;
        cyc();
        check("rm_psel", 64'(psel), 64'd0);
        check("rm_penable", 64'(penable), 64'd0);
        check("rm_no_rsp", 64'(rsp_valid), 64'd0);
        preset = 1'b0;
        #1;
        check("rm_ready_after", 64'(req_ready), 64'd1);
        cyc();
        check("rm_no_rsp_after", 64'(rsp_valid), 64'd0);

        // Back-to-back reads with req_valid held high
        pready    = 1'b1;
        k         = 0;
        r         = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h300;
        for (int t = 1; t <= 9; t++) begin
            cyc();
            check($sformatf("bb_psel_t%0d", t), 64'(psel), 64'((t % 3) != 0));
            check($sformatf("bb_rsp_t%0d", t), 64'(rsp_valid), 64'((t % 3) == 0));
            if ((t % 3) == 0) begin
                check($sformatf("bb_rdata_%0d", r), 64'(rsp_rdata), 64'(32'h1000 + 32'(r)));
                r++;
            end
            if ((t % 3) == 1) begin
                check($sformatf("bb_paddr_%0d", k), 64'(paddr), 64'(32'h300 + 32'(4 * k)));
                k++;
                if (k < 3) req_addr = 32'h300 + 32'(4 * k);
                else req_valid = 1'b0;
            end
            if ((t % 3) == 2) prdata = 32'h1000 + 32'(k - 1);
        end
        check("bb_rsp_count", 64'(r), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
